// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: shared pipe/bus types and FSM states for the memory stage.
package memory_stage_pkg;
    localparam int XLEN   = 64;
    localparam int STRB_W = XLEN / 8;

    typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

    typedef struct packed {
        logic   RegWrite;
        logic   MemRead;
        logic   MemWrite;
        logic   mem_unsigned;
        msize_t msize;
    } ctl_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        ctl_t            ctl;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] alu;
        logic            valid;
    } execute_data_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        ctl_t            ctl;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] rdata;
        logic            valid;
    } memory_data_t;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   addr;
        msize_t            size;
        logic [STRB_W-1:0] strobe;
        logic [XLEN-1:0]   data;
    } dbus_req_t;

    typedef struct packed {
        logic            addr_ok;
        logic            data_ok;
        logic [XLEN-1:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN} mstate_t;
endpackage

// File: rtl/memory_stage_memextend.sv
// memory_stage_memextend: load extraction/extension, store lane alignment and
// alignment check for one doubleword-wide data bus access.
module memory_stage_memextend
    import memory_stage_pkg::*;
(
    input  logic [2:0]        addr_i,
    input  msize_t            msize_i,
    input  logic              unsigned_i,
    input  logic [XLEN-1:0]   rs2_i,
    input  logic [XLEN-1:0]   rdata_i,
    output logic [XLEN-1:0]   ld_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic [STRB_W-1:0] strobe_o,
    output logic              misalign_o
);
    logic [5:0]      sh;
    logic [3:0]      nb;
    logic [XLEN-1:0] s;

    assign sh = {addr_i, 3'b000};
    assign nb = 4'd1 << msize_i;
    assign s  = rdata_i >> sh;

    assign ld_o = msize_i == MSIZE1 ? {{56{~unsigned_i & s[7]}}, s[7:0]}
                : msize_i == MSIZE2 ? {{48{~unsigned_i & s[15]}}, s[15:0]}
                : msize_i == MSIZE4 ? {{32{~unsigned_i & s[31]}}, s[31:0]}
                : s;

    assign wdata_o    = rs2_i << sh;
    assign strobe_o   = STRB_W'((9'd1 << nb) - 9'd1) << addr_i;
    assign misalign_o = |(addr_i & 3'(nb - 4'd1));
endmodule

// File: rtl/memory_stage.sv
// memory_stage: drives one dbus transaction per load/store from the E/M register
// and stalls the pipeline until data_ok; flushed in-flight accesses are drained.
module memory_stage
    import memory_stage_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  execute_data_t dataE,
    input  logic          flush,
    output dbus_req_t     dreq,
    input  dbus_resp_t    dresp,
    output memory_data_t  dataM_nxt,
    output logic          stallM,
    output logic          misalign
);
    mstate_t           state_q, state_d;
    logic              mem_op, mis, unused_addr_ok;
    logic [XLEN-1:0]   ld, wdata;
    logic [STRB_W-1:0] strb;

    assign mem_op         = dataE.valid & (dataE.ctl.MemRead | dataE.ctl.MemWrite);
    assign unused_addr_ok = dresp.addr_ok;

    memory_stage_memextend u_ext (
        .addr_i     (dataE.alu[2:0]),
        .msize_i    (dataE.ctl.msize),
        .unsigned_i (dataE.ctl.mem_unsigned),
        .rs2_i      (dataE.rs2),
        .rdata_i    (dresp.data),
        .ld_o       (ld),
        .wdata_o    (wdata),
        .strobe_o   (strb),
        .misalign_o (mis)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;

    always_comb begin
        state_d         = state_q;
        dreq.valid      = 1'b0;
        dreq.addr       = dataE.alu;
        dreq.size       = dataE.ctl.msize;
        dreq.strobe     = dataE.ctl.MemWrite ? strb : '0;
        dreq.data       = wdata;
        dataM_nxt.pc    = dataE.pc;
        dataM_nxt.ctl   = dataE.ctl;
        dataM_nxt.alu   = dataE.alu;
        dataM_nxt.rdata = (dataE.ctl.MemRead & ~dataE.ctl.MemWrite) ? ld : '0;
        dataM_nxt.valid = 1'b0;
        stallM          = 1'b0;
        misalign        = 1'b0;
        unique case (state_q)
            IDLE:
                if (mem_op & ~flush) begin
                    if (mis) misalign = 1'b1;
                    else begin
                        dreq.valid = 1'b1;
                        if (dresp.data_ok) dataM_nxt.valid = 1'b1;
                        else begin
                            stallM  = 1'b1;
                            state_d = WAIT;
                        end
                    end
                end else dataM_nxt.valid = dataE.valid & ~flush & ~mem_op;
            WAIT: begin
                dreq.valid      = 1'b1;
                stallM          = ~dresp.data_ok;
                dataM_nxt.valid = dresp.data_ok & dataE.valid & ~flush;
                state_d         = dresp.data_ok ? IDLE : (flush ? DRAIN : WAIT);
            end
            DRAIN: begin
                dreq.valid = 1'b1;
                stallM     = ~dresp.data_ok;
                state_d    = dresp.data_ok ? IDLE : DRAIN;
            end
            default: state_d = IDLE;
        endcase
        // Async reset must silence the bus and pipeline controls before any edge.
        if (reset) begin
            dreq.valid      = 1'b0;
            dataM_nxt.valid = 1'b0;
            stallM          = 1'b0;
            misalign        = 1'b0;
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: randomized and directed load/store sequences checked against a
// transaction-level model of the memory stage.
module tb_memory_stage;
    import memory_stage_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    execute_data_t dataE;
    dbus_req_t     dreq;
    dbus_resp_t    dresp;
    memory_data_t  dataM_nxt;
    logic          stallM, misalign;
    int            n_tests = 0, n_fail = 0;

    memory_stage dut (
        .clk       (clk),
        .reset     (reset),
        .dataE     (dataE),
        .flush     (flush),
        .dreq      (dreq),
        .dresp     (dresp),
        .dataM_nxt (dataM_nxt),
        .stallM    (stallM),
        .misalign  (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_load(input logic [63:0] mem, input logic [2:0] off,
                                               input int bytes, input logic uns);
        logic [63:0] v, m;
        v = mem >> (8 * off);
        if (bytes == 8) return v;
        m = (64'd1 << (8 * bytes)) - 64'd1;
        v = v & m;
        if (!uns && v[8 * bytes - 1]) v = v | ~m;
        return v;
    endfunction

    // Called just after a rising edge; walks the instruction cycle by cycle.
    task automatic run_instr(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                             input logic [63:0] addr, input logic [63:0] rs2, input logic [63:0] mem,
                             input int lat, input int fl);
        int          bytes, off, k;
        logic        memop, aligned, done;
        logic [7:0]  exp_strb;
        logic [63:0] pc, got_lanes, exp_lanes;
        bytes   = 1 << sz;
        off     = int'(addr[2:0]);
        memop   = rd | wr;
        aligned = (addr % 64'(bytes)) == 0;
        pc      = {32'h0, $urandom};
        dataE.pc               = pc;
        dataE.ctl.RegWrite     = rd;
        dataE.ctl.MemRead      = rd;
        dataE.ctl.MemWrite     = wr;
        dataE.ctl.mem_unsigned = uns;
        dataE.ctl.msize        = msize_t'(sz);
        dataE.rs2              = rs2;
        dataE.alu              = addr;
        dataE.valid            = 1'b1;
        exp_strb = 8'(((1 << bytes) - 1) << off);
        exp_lanes = '0;
        got_lanes = '0;
        for (int i = 0; i < 8; i++)
            if (exp_strb[i]) begin
                exp_lanes[8*i +: 8] = rs2[8*(i-off) +: 8];
            end
        k = 0;
        done = 1'b0;
        while (!done) begin
            flush          = (k == fl);
            dresp.data_ok  = (k == lat);
            dresp.addr_ok  = 1'b1;
            dresp.data     = mem;
            @(negedge clk);
            if (!memop) begin
                check("pass_valid", 64'(dataM_nxt.valid), 64'(fl != 0));
                check("pass_pc", dataM_nxt.pc, pc);
                check("pass_rdata", dataM_nxt.rdata, 64'd0);
                check("pass_dreq", 64'(dreq.valid), 64'd0);
                check("pass_stall", 64'(stallM), 64'd0);
                done = 1'b1;
            end else if (fl == 0 || !aligned) begin
                check("mis_flag", 64'(misalign), 64'(!aligned && fl != 0));
                check("mis_dreq", 64'(dreq.valid), 64'd0);
                check("mis_valid", 64'(dataM_nxt.valid), 64'd0);
                check("mis_stall", 64'(stallM), 64'd0);
                done = 1'b1;
            end else begin
                check("dreq_valid", 64'(dreq.valid), 64'd1);
                check("dreq_addr", dreq.addr, addr);
                check("dreq_size", 64'(dreq.size), 64'(sz));
                check("dreq_strobe", 64'(dreq.strobe), wr ? 64'(exp_strb) : 64'd0);
                if (wr) begin
                    for (int i = 0; i < 8; i++)
                        if (exp_strb[i]) got_lanes[8*i +: 8] = dreq.data[8*i +: 8];
                    check("dreq_data", got_lanes, exp_lanes);
                end
                check("stall", 64'(stallM), 64'(k < lat));
                check("misalign_0", 64'(misalign), 64'd0);
                check("valid", 64'(dataM_nxt.valid), 64'(k == lat && fl > lat));
                if (k == lat && fl > lat)
                    check("rdata", dataM_nxt.rdata,
                          wr ? 64'd0 : model_load(mem, addr[2:0], bytes, uns));
                done = (k == lat);
            end
            @(posedge clk);
            #1;
            k++;
        end
        flush         = 1'b0;
        dresp.data_ok = 1'b0;
        dataE.valid   = 1'b0;
    endtask

    initial begin
        logic [1:0]  sz;
        logic [63:0] a;
        int          kind, lat, fl;
        reset = 1'b1;
        flush = 1'b0;
        dresp = '0;
        dataE = '0;
        dataE.valid       = 1'b1;
        dataE.ctl.MemRead = 1'b1;
        dataE.ctl.msize   = MSIZE8;
        dataE.alu         = 64'h8000_0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_dreq", 64'(dreq.valid), 64'd0);
        check("rst_stall", 64'(stallM), 64'd0);
        check("rst_valid", 64'(dataM_nxt.valid), 64'd0);
        check("rst_misalign", 64'(misalign), 64'd0);
        @(posedge clk);
        #1;
        dataE.valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_instr(1, 0, 2'd3, 0, 64'h8000_0008, 64'd0, 64'h1122334455667788, 0, 99);
        run_instr(1, 0, 2'd0, 0, 64'h8000_0003, 64'd0, 64'h0000000080000000, 0, 99);
        run_instr(1, 0, 2'd0, 1, 64'h8000_0003, 64'd0, 64'h0000000080000000, 0, 99);
        run_instr(0, 1, 2'd1, 0, 64'h8000_0006, 64'hBEEF, 64'd0, 1, 99);
        run_instr(1, 0, 2'd2, 0, 64'h8000_0000, 64'd0, 64'hCAFEF00D_87654321, 3, 99);
        run_instr(1, 0, 2'd3, 0, 64'h8000_0010, 64'd0, 64'h55, 3, 1);
        run_instr(1, 0, 2'd2, 0, 64'h8000_0002, 64'd0, 64'd0, 0, 99);
        run_instr(0, 0, 2'd0, 0, 64'h1234, 64'd0, 64'd0, 0, 99);
        run_instr(1, 0, 2'd3, 0, 64'h8000_0020, 64'd0, 64'd7, 0, 0);
        run_instr(1, 0, 2'd3, 0, 64'h8000_0028, 64'd0, 64'd7, 2, 2);
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            sz   = 2'($urandom_range(0, 3));
            a    = {32'h0, 32'h8000_0000 + $urandom_range(0, 4095)};
            if ($urandom_range(0, 4) != 0) a = a & ~(64'(1 << sz) - 64'd1);
            lat  = $urandom_range(0, 3);
            fl   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lat) : 99;
            run_instr(kind >= 2 && kind < 6, kind >= 6, sz, 1'($urandom),
                      a, {$urandom, $urandom}, {$urandom, $urandom}, lat, fl);
        end
        // Asynchronous reset while an access is outstanding.
        dataE.valid        = 1'b1;
        dataE.ctl.MemRead  = 1'b1;
        dataE.ctl.MemWrite = 1'b0;
        dataE.ctl.msize    = MSIZE8;
        dataE.alu          = 64'h8000_0040;
        dresp.data_ok      = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2;
        check("wait_stall", 64'(stallM), 64'd1);
        check("wait_dreq", 64'(dreq.valid), 64'd1);
        reset = 1'b1;
        #1;
        check("arst_dreq", 64'(dreq.valid), 64'd0);
        check("arst_stall", 64'(stallM), 64'd0);
        check("arst_valid", 64'(dataM_nxt.valid), 64'd0);
        dataE.valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_instr(1, 0, 2'd1, 0, 64'h8000_0002, 64'd0, 64'h0000_8001_0000_0000, 0, 99);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
